unidad_control_if: RTL and testbench

Sequencing controller on the consuming side of the fetch stage. It receives an algorithm request and drives `sel_dir`/`sel_pc` so the fetch stage loads that algorithm's ROM start address. It then consumes the `instruccion` stream, tags each word valid, splits it into fields and stops at the END opcode. It sits between the top-level command interface and the vector execute stages.

---
 rtl/proc_vec_pkg.sv | 37 +++
 rtl/decod_instr.sv | 37 +++
 rtl/unidad_control_if.sv | 91 +++++++++
 tb/tb_unidad_control_if.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_vec_pkg.sv
// Shared definitions for the vector processor control path: FSM states,
// algorithm indices, instruction field layout and the END opcode.
package proc_vec_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RUN,
        ST_DONE
    } estado_t;

    // Algorithm indices as seen on the command interface
    localparam logic [2:0] ALG_XOR_ENC   = 3'd0;
    localparam logic [2:0] ALG_XOR_DEC   = 3'd1;
    localparam logic [2:0] ALG_SHIFT_ENC = 3'd2;
    localparam logic [2:0] ALG_SHIFT_DEC = 3'd3;
    localparam logic [2:0] ALG_CIRC_ENC  = 3'd4;
    localparam logic [2:0] ALG_CIRC_DEC  = 3'd5;
    localparam logic [2:0] ALG_ADD_ENC   = 3'd6;
    localparam logic [2:0] ALG_ADD_DEC   = 3'd7;

    // Instruction word layout: [13:10] opcode, [9:7] vd, [6:4] vs, [3:0] imm
    localparam int INSTR_W = 14;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 4;
    localparam int OPC_LSB = 10;
    localparam int VD_LSB  = 7;
    localparam int VS_LSB  = 4;
    localparam int IMM_LSB = 0;

    // Opcode that terminates an algorithm
    localparam logic [OPC_W-1:0] OP_END = 4'hF;

endpackage

// File: rtl/decod_instr.sv
// Combinational instruction field split. Fields are forced to zero unless
// the word is an issued, non-END instruction.
module decod_instr
    import proc_vec_pkg::*;
#(
    parameter logic [3:0] OP_END = proc_vec_pkg::OP_END
) (
    input  logic               en,
    input  logic [INSTR_W-1:0] instruccion,
    output logic               instr_valid,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   vd,
    output logic [REG_W-1:0]   vs,
    output logic [IMM_W-1:0]   imm
);

    logic [OPC_W-1:0] opcode_raw;

    assign opcode_raw = instruccion[OPC_LSB +: OPC_W];

    // Qualify the word and gate every field with the valid flag
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        instr_valid = en && (opcode_raw != OP_END);
        opcode      = '0;
        vd          = '0;
        vs          = '0;
        imm         = '0;
        if (instr_valid) begin
            opcode = opcode_raw;
            vd     = instruccion[VD_LSB  +: REG_W];
            vs     = instruccion[VS_LSB  +: REG_W];
            imm    = instruccion[IMM_LSB +: IMM_W];
        end
    end

endmodule

// File: rtl/unidad_control_if.sv
// Sequencing controller behind the fetch stage: selects an algorithm's ROM
// start address, waits out the ROM read latency, then issues instructions
// until END or the watchdog limit.
module unidad_control_if
    import proc_vec_pkg::*;
#(
    parameter int         MAX_LEN = 32,
    parameter logic [3:0] OP_END  = proc_vec_pkg::OP_END
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         algoritmo,
    input  logic [INSTR_W-1:0] instruccion,
    output logic [2:0]         sel_dir,
    output logic               sel_pc,
    output logic               instr_valid,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   vd,
    output logic [REG_W-1:0]   vs,
    output logic [IMM_W-1:0]   imm,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [5:0] CNT_LAST = 6'(MAX_LEN - 1);

    estado_t    state;
    logic [2:0] alg_reg;
    logic [5:0] cnt;
    logic       run_en;

    // Moore decode of the state register
    assign run_en  = (state == ST_RUN);
    assign sel_pc  = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DONE);
    assign busy    = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign sel_dir = alg_reg;

    decod_instr #(
        .OP_END (OP_END)
    ) u_decod (
        .en          (run_en),
        .instruccion (instruccion),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .vd          (vd),
        .vs          (vs),
        .imm         (imm)
    );

    // Sequencer FSM with algorithm latch, issue counter and watchdog flag
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= ST_IDLE;
            alg_reg <= '0;
            cnt     <= '0;
            error   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        alg_reg <= algoritmo;
                        error   <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_WAIT;
                ST_WAIT: state <= ST_RUN;
                ST_RUN: begin
                    if (!instr_valid) begin
                        // END opcode reached
                        state <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Watchdog: last allowed instruction issued this cycle
                        error <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_control_if.sv
// Self-checking bench for unidad_control_if with a behavioural fetch stage
// (PC register plus registered-read ROM, start address = algorithm * 3).
module tb_unidad_control_if;

    localparam int MAX_LEN = 32;
    localparam int TMO     = 120;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  algoritmo;
    logic [13:0] instruccion;
    logic [2:0]  sel_dir;
    logic        sel_pc;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [2:0]  vd;
    logic [2:0]  vs;
    logic [3:0]  imm;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    logic [13:0] rom [256];
    logic [7:0]  pc;

    unidad_control_if #(
        .MAX_LEN (MAX_LEN),
        .OP_END  (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .algoritmo   (algoritmo),
        .instruccion (instruccion),
        .sel_dir     (sel_dir),
        .sel_pc      (sel_pc),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .vd          (vd),
        .vs          (vs),
        .imm         (imm),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] start_of(input logic [2:0] a);
        return 8'(a) * 8'd3;
    endfunction

    // Fetch stage model: PC loads start address or increments; ROM read is registered
    always @(posedge clk) begin
        if (rst) begin
            pc          <= 8'd0;
            instruccion <= 14'd0;
        end else begin
            pc          <= sel_pc ? start_of(sel_dir) : pc + 8'd1;
            instruccion <= rom[pc];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] rand_op();
        return {4'($urandom_range(0, 14)), 10'($urandom)};
    endfunction

    function automatic logic [13:0] end_word();
        return {4'hF, 10'($urandom)};
    endfunction

    // One full algorithm run, checked against expected valid count, latency and error
    task automatic run_case(input string name, input logic [2:0] alg, input int n_ops,
                            input bit with_end, input bit mid_start,
                            input int exp_valid, input int exp_lat, input bit exp_err);
        logic [7:0]  base;
        logic [13:0] w;
        logic [13:0] exp_q[$];
        int          cyc;
        int          nvalid;
        int          gate_err;
        bit          seen_done;
        base = start_of(alg);
        for (int k = 0; k < (with_end ? n_ops : MAX_LEN + 4); k++) rom[base + 8'(k)] = rand_op();
        if (with_end) rom[base + 8'(n_ops)] = end_word();
        for (int k = 0; k < exp_valid; k++) exp_q.push_back(rom[base + 8'(k)]);

        @(posedge clk); #1;
        check({name, " idle"}, {busy, sel_pc, done}, 3'b010);
        start     = 1'b1;
        algoritmo = alg;
        @(posedge clk); #1;
        start     = 1'b0;
        algoritmo = 3'($urandom);
        check({name, " load"}, {busy, sel_pc, 1'b0, sel_dir}, {1'b1, 1'b1, 1'b0, alg});
        check({name, " error_clr"}, 32'(error), 32'd0);

        cyc = 0; nvalid = 0; gate_err = 0; seen_done = 1'b0;
        while (!seen_done && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
            if (instr_valid) begin
                nvalid++;
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check({name, " fields"}, {opcode, vd, vs, imm}, w);
                end else begin
                    gate_err++;
                end
            end else if ({opcode, vd, vs, imm} != 14'd0) begin
                gate_err++;
            end
            if (done) begin
                seen_done = 1'b1;
                check({name, " latency"}, cyc, exp_lat);
                check({name, " error"}, 32'(error), 32'(exp_err));
                check({name, " done_out"}, {busy, sel_pc, 1'b0, sel_dir}, {1'b0, 1'b1, 1'b0, alg});
            end else if (busy !== 1'b1 || sel_pc !== 1'b0) begin
                gate_err++;
            end
            if (mid_start && cyc == 3) begin
                start     = 1'b1;
                algoritmo = ~alg;
            end else if (mid_start && cyc == 4) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({name, " timeout"}, 32'(seen_done), 32'd1);
        check({name, " n_valid"}, nvalid, exp_valid);
        check({name, " gating"}, gate_err, 0);
    endtask

    typedef struct {
        string      name;
        logic [2:0] alg;
        int         n_ops;
        bit         with_end;
        bit         mid_start;
        int         exp_valid;
        int         exp_lat;
        bit         exp_err;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   cyc;
        int   bad;
        int   nvalid;

        rst       = 1'b1;
        start     = 1'b0;
        algoritmo = 3'd0;
        for (int i = 0; i < 256; i++) rom[i] = {4'hF, 10'd0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", {busy, done, sel_pc, instr_valid, sel_dir, error},
              {1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0});
        check("reset fields", {opcode, vd, vs, imm}, 14'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hand-derived vectors: {name, alg, n_ops, end, mid_start, valid, latency, error}
        vecs.push_back('{"alg4_3ops",    3'd4,  3, 1'b1, 1'b0,  3,  6, 1'b0});
        vecs.push_back('{"alg0_end1st",  3'd0,  0, 1'b1, 1'b0,  0,  3, 1'b0});
        vecs.push_back('{"alg6_wdog",    3'd6,  0, 1'b0, 1'b0, 32, 34, 1'b1});
        vecs.push_back('{"alg1_31ops",   3'd1, 31, 1'b1, 1'b0, 31, 34, 1'b0});
        vecs.push_back('{"alg5_32ops",   3'd5, 32, 1'b1, 1'b0, 32, 34, 1'b1});
        vecs.push_back('{"alg2_midstrt", 3'd2,  6, 1'b1, 1'b1,  6,  9, 1'b0});
        vecs.push_back('{"alg3_1op",     3'd3,  1, 1'b1, 1'b0,  1,  4, 1'b0});
        foreach (vecs[i])
            run_case(vecs[i].name, vecs[i].alg, vecs[i].n_ops, vecs[i].with_end,
                     vecs[i].mid_start, vecs[i].exp_valid, vecs[i].exp_lat, vecs[i].exp_err);

        // Randomized runs against the rule-level model
        for (int r = 0; r < 16; r++) begin
            logic [2:0] a;
            int  n, ev, el;
            bit  we, ms, ee;
            a  = 3'($urandom);
            n  = $urandom_range(0, 36);
            we = ($urandom_range(0, 3) != 0);
            ms = (n >= 3) && $urandom_range(0, 1) == 1;
            ee = !(we && n < MAX_LEN);
            ev = ee ? MAX_LEN : n;
            el = ee ? MAX_LEN + 2 : n + 3;
            run_case($sformatf("rand%0d", r), a, n, we, ms, ev, el, ee);
        end

        // Reset mid-RUN: alg 2, after three issued instructions
        for (int k = 0; k < 10; k++) rom[start_of(3'd2) + 8'(k)] = rand_op();
        rom[start_of(3'd2) + 8'd10] = end_word();
        @(posedge clk); #1;
        start = 1'b1; algoritmo = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; nvalid = 0;
        while (nvalid < 3 && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
            if (instr_valid) nvalid++;
        end
        check("rstmid reached", nvalid, 3);
        rst = 1'b1;
        #1;
        check("rstmid outs", {busy, done, sel_pc, instr_valid, sel_dir, error},
              {1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0});
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        check("rstmid quiet", bad, 0);

        // start held high, alg 7: back-to-back runs with a single IDLE cycle
        rom[start_of(3'd7)]        = rand_op();
        rom[start_of(3'd7) + 8'd1] = rand_op();
        rom[start_of(3'd7) + 8'd2] = end_word();
        @(posedge clk); #1;
        start = 1'b1; algoritmo = 3'd7;
        cyc = 0;
        while (!done && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held first_done", cyc, 6);
        @(posedge clk); #1;
        check("held idle_gap", {busy, sel_pc}, 2'b01);
        @(posedge clk); #1;
        check("held reload", {busy, sel_pc, 1'b0, sel_dir}, {1'b1, 1'b1, 1'b0, 3'd7});
        cyc = 0;
        while (!done && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("held second_done", cyc, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("held stop", {busy, done}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
